// File: rtl/falu_int2fp_sched.sv
// Integer-to-FP conversion scheduler: round-robin arbitration of two issue lanes,
// a registered operand stage, a combinational converter and a registered result stage.
`timescale 1ns/1ps
module falu_int2fp_sched #(
    parameter int TAG_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [2:0]       frm_csr,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [63:0]      req0_operand,
    input  logic [2:0]       req0_rm,
    input  logic             req0_is_double,
    input  logic             req0_is_word,
    input  logic             req0_is_unsigned,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [63:0]      req1_operand,
    input  logic [2:0]       req1_rm,
    input  logic             req1_is_double,
    input  logic             req1_is_word,
    input  logic             req1_is_unsigned,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [63:0]      res_data,
    output logic [4:0]       res_fflags,
    output logic             res_illegal,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_lane,
    output logic             busy
);

    logic             rr_last;
    logic             s1_valid;
    logic [63:0]      s1_operand;
    logic [2:0]       s1_rm;
    logic             s1_is_double;
    logic             s1_is_word;
    logic             s1_is_unsigned;
    logic [TAG_W-1:0] s1_tag;
    logic             s1_lane;
    logic             s1_illegal;

    logic             s2_valid;
    logic [63:0]      s2_data;
    logic [4:0]       s2_fflags;
    logic             s2_illegal;
    logic [TAG_W-1:0] s2_tag;
    logic             s2_lane;

    logic grant0, grant1, s2_load, s1_free, accept0, accept1, accept;

    logic [63:0]      sel_operand;
    logic [2:0]       sel_rm;
    logic [2:0]       rm_eff;
    logic             sel_is_double, sel_is_word, sel_is_unsigned, sel_illegal;
    logic [TAG_W-1:0] sel_tag;

    // rr_last == 1 means lane 1 was served last, so lane 0 wins the next tie
    always_comb begin
        grant0  = req0_valid & (~req1_valid | rr_last);
        grant1  = req1_valid & (~req0_valid | ~rr_last);
        s2_load = s1_valid & (~s2_valid | res_ready);
        s1_free = ~s1_valid | s2_load;
        accept0 = grant0 & s1_free & ~flush & rst_n;
        accept1 = grant1 & s1_free & ~flush & rst_n;
        accept  = accept0 | accept1;
    end

    assign req0_ready = accept0;
    assign req1_ready = accept1;

    always_comb begin
        sel_operand     = accept1 ? req1_operand     : req0_operand;
        sel_rm          = accept1 ? req1_rm          : req0_rm;
        sel_is_double   = accept1 ? req1_is_double   : req0_is_double;
        sel_is_word     = accept1 ? req1_is_word     : req0_is_word;
        sel_is_unsigned = accept1 ? req1_is_unsigned : req0_is_unsigned;
        sel_tag         = accept1 ? req1_tag         : req0_tag;
        rm_eff          = (sel_rm == 3'b111) ? frm_csr : sel_rm;
        sel_illegal     = rm_eff[2] & (rm_eff[1] | rm_eff[0]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_last        <= 1'b1;
            s1_valid       <= 1'b0;
            s1_operand     <= '0;
            s1_rm          <= '0;
            s1_is_double   <= 1'b0;
            s1_is_word     <= 1'b0;
            s1_is_unsigned <= 1'b0;
            s1_tag         <= '0;
            s1_lane        <= 1'b0;
            s1_illegal     <= 1'b0;
        end else begin
            if (flush) begin
                s1_valid <= 1'b0;
            end else if (accept) begin
                s1_valid       <= 1'b1;
                s1_operand     <= sel_operand;
                s1_rm          <= sel_illegal ? 3'b001 : rm_eff;
                s1_is_double   <= sel_is_double;
                s1_is_word     <= sel_is_word;
                s1_is_unsigned <= sel_is_unsigned;
                s1_tag         <= sel_tag;
                s1_lane        <= accept1;
                s1_illegal     <= sel_illegal;
            end else if (s2_load) begin
                s1_valid <= 1'b0;
            end
            if (accept) begin
                rr_last <= accept1;
            end
        end
    end

    logic [63:0] src, mag, norm, cvt_data;
    logic        neg, lsb, guard, sticky, round_up, cvt_nx;
    logic [5:0]  msb;
    logic [7:0]  sp_exp;
    logic [10:0] dp_exp;
    logic [30:0] sp_field;
    logic [62:0] dp_field;

    // Normalise the magnitude so its leading one sits at bit 63; zero stays zero
    always_comb begin
        if (s1_is_word) begin
            src = s1_is_unsigned ? {32'b0, s1_operand[31:0]}
                                 : {{32{s1_operand[31]}}, s1_operand[31:0]};
        end else begin
            src = s1_operand;
        end
        neg = ~s1_is_unsigned & src[63];
        mag = neg ? (~src + 64'd1) : src;
        msb = '0;
        for (int i = 0; i < 64; i++) begin
            if (mag[i]) begin
                msb = 6'(i);
            end
        end
        norm   = mag << (6'd63 - msb);
        lsb    = s1_is_double ? norm[11] : norm[40];
        guard  = s1_is_double ? norm[10] : norm[39];
        sticky = s1_is_double ? (|norm[9:0]) : (|norm[38:0]);
        case (s1_rm)
            3'b000:  round_up = guard & (sticky | lsb);
            3'b010:  round_up = neg & (guard | sticky);
            3'b011:  round_up = ~neg & (guard | sticky);
            3'b100:  round_up = guard;
            default: round_up = 1'b0;
        endcase
        sp_exp   = {2'b00, msb} + 8'd127;
        dp_exp   = {5'b00000, msb} + 11'd1023;
        sp_field = {sp_exp, norm[62:40]} + {30'b0, round_up};
        dp_field = {dp_exp, norm[62:11]} + {62'b0, round_up};
        cvt_nx   = guard | sticky;
        if (!norm[63]) begin
            cvt_data = s1_is_double ? 64'h0 : 64'hFFFF_FFFF_0000_0000;
        end else if (s1_is_double) begin
            cvt_data = {neg, dp_field};
        end else begin
            cvt_data = {32'hFFFF_FFFF, neg, sp_field};
        end
    end

    // Result registers only change on a load, which keeps them stable under backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_fflags  <= '0;
            s2_illegal <= 1'b0;
            s2_tag     <= '0;
            s2_lane    <= 1'b0;
        end else begin
            if (flush) begin
                s2_valid <= 1'b0;
            end else if (s2_load) begin
                s2_valid   <= 1'b1;
                s2_data    <= s1_illegal ? 64'h0 : cvt_data;
                s2_fflags  <= {4'b0000, cvt_nx & ~s1_illegal};
                s2_illegal <= s1_illegal;
                s2_tag     <= s1_tag;
                s2_lane    <= s1_lane;
            end else if (res_ready) begin
                s2_valid <= 1'b0;
            end
        end
    end

    assign res_valid   = s2_valid;
    assign res_data    = s2_data;
    assign res_fflags  = s2_fflags;
    assign res_illegal = s2_illegal;
    assign res_tag     = s2_tag;
    assign res_lane    = s2_lane;
    assign busy        = s1_valid | s2_valid;

endmodule

// File: tb/tb_falu_int2fp_sched.sv
// Bench for falu_int2fp_sched: scoreboard driven by an arithmetic conversion model,
// plus directed vectors with hand-computed literal results.
`timescale 1ns/1ps
module tb_falu_int2fp_sched;

    localparam int TAG_W = 6;

    logic             clk = 1'b0;
    logic             rst_n, flush, res_ready;
    logic [2:0]       frm_csr;
    logic             req0_valid, req0_ready, req0_is_double, req0_is_word, req0_is_unsigned;
    logic [63:0]      req0_operand;
    logic [2:0]       req0_rm;
    logic [TAG_W-1:0] req0_tag;
    logic             req1_valid, req1_ready, req1_is_double, req1_is_word, req1_is_unsigned;
    logic [63:0]      req1_operand;
    logic [2:0]       req1_rm;
    logic [TAG_W-1:0] req1_tag;
    logic             res_valid, res_illegal, res_lane, busy;
    logic [63:0]      res_data;
    logic [4:0]       res_fflags;
    logic [TAG_W-1:0] res_tag;

    always #5 clk = ~clk;

    falu_int2fp_sched #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .frm_csr(frm_csr),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_operand(req0_operand),
        .req0_rm(req0_rm), .req0_is_double(req0_is_double), .req0_is_word(req0_is_word),
        .req0_is_unsigned(req0_is_unsigned), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_operand(req1_operand),
        .req1_rm(req1_rm), .req1_is_double(req1_is_double), .req1_is_word(req1_is_word),
        .req1_is_unsigned(req1_is_unsigned), .req1_tag(req1_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_fflags(res_fflags), .res_illegal(res_illegal), .res_tag(res_tag),
        .res_lane(res_lane), .busy(busy)
    );

    typedef struct {
        logic [63:0]      data;
        logic [4:0]       flags;
        logic             ill;
        logic [TAG_W-1:0] tag;
        logic             lane;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   delivered = 0;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%016h expected 0x%016h at %0t", name, act, exp, $time);
        end
    endtask

    // Exact arithmetic: truncate to precision, then decide rounding from the discarded remainder
    function automatic void model_cvt(input logic [63:0] op, input logic [2:0] rm, input logic [2:0] frm,
                                      input logic dbl, input logic word, input logic uns,
                                      output logic [63:0] data, output logic [4:0] flags, output logic ill);
        logic [2:0]  r;
        logic [63:0] v, mag, q, rem, half;
        logic        neg, up;
        int          p, prec, sh;
        r     = (rm == 3'b111) ? frm : rm;
        ill   = (r == 3'd5) || (r == 3'd6) || (r == 3'd7);
        data  = 64'h0;
        flags = 5'h0;
        if (ill) return;
        if (word) v = uns ? {32'b0, op[31:0]} : {{32{op[31]}}, op[31:0]};
        else      v = op;
        neg = !uns && v[63];
        mag = neg ? (~v + 64'd1) : v;
        if (mag == 64'd0) begin
            data = dbl ? 64'h0 : 64'hFFFF_FFFF_0000_0000;
            return;
        end
        p = 0;
        for (int i = 0; i < 64; i++) if (mag[i]) p = i;
        prec = dbl ? 53 : 24;
        rem  = 64'd0;
        half = 64'd0;
        if (p < prec) begin
            q = mag << (prec - 1 - p);
        end else begin
            sh   = p - (prec - 1);
            q    = mag >> sh;
            rem  = mag - (q << sh);
            half = 64'd1 << (sh - 1);
        end
        up = 1'b0;
        if (rem != 64'd0) begin
            case (r)
                3'b000:  up = (rem > half) || ((rem == half) && q[0]);
                3'b010:  up = neg;
                3'b011:  up = !neg;
                3'b100:  up = (rem >= half);
                default: up = 1'b0;
            endcase
        end
        q = q + {63'b0, up};
        if (q == (64'd1 << prec)) begin
            q = q >> 1;
            p = p + 1;
        end
        flags = {4'b0, rem != 64'd0};
        if (dbl) data = {neg, 11'(p + 1023), q[51:0]};
        else     data = {32'hFFFF_FFFF, neg, 8'(p + 127), q[22:0]};
    endfunction

    function automatic exp_t make_exp(input logic lane);
        exp_t e;
        if (lane) begin
            model_cvt(req1_operand, req1_rm, frm_csr, req1_is_double, req1_is_word, req1_is_unsigned,
                      e.data, e.flags, e.ill);
            e.tag = req1_tag;
        end else begin
            model_cvt(req0_operand, req0_rm, frm_csr, req0_is_double, req0_is_word, req0_is_unsigned,
                      e.data, e.flags, e.ill);
            e.tag = req0_tag;
        end
        e.lane = lane;
        return e;
    endfunction

    logic        prev_hold = 1'b0;
    logic [63:0] prev_data;
    logic [63:0] prev_misc;
    exp_t        mon_e;

    // Single compare process: occupancy, ordering, content and hold stability every cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
            prev_hold = 1'b0;
        end else begin
            check_output("one_ready", {63'b0, req0_ready & req1_ready}, 64'd0);
            check_output("busy", {63'b0, busy}, {63'b0, sb_q.size() != 0});
            if (res_valid) check_output("res_pending", {63'b0, sb_q.size() != 0}, 64'd1);
            if (prev_hold) begin
                check_output("hold_valid", {63'b0, res_valid}, 64'd1);
                check_output("hold_data", res_data, prev_data);
                check_output("hold_misc", {51'b0, res_fflags, res_illegal, res_lane, res_tag}, prev_misc);
            end
            if (res_valid && res_ready && sb_q.size() != 0) begin
                mon_e = sb_q.pop_front();
                check_output("sb_data", res_data, mon_e.data);
                check_output("sb_misc", {51'b0, res_fflags, res_illegal, res_lane, res_tag},
                             {51'b0, mon_e.flags, mon_e.ill, mon_e.lane, mon_e.tag});
                delivered++;
            end
            prev_hold = res_valid & !res_ready & !flush;
            prev_data = res_data;
            prev_misc = {51'b0, res_fflags, res_illegal, res_lane, res_tag};
            if (flush) begin
                sb_q.delete();
            end else begin
                if (req0_valid && req0_ready) sb_q.push_back(make_exp(1'b0));
                if (req1_valid && req1_ready) sb_q.push_back(make_exp(1'b1));
            end
        end
    end

    task automatic drive_lane(input logic lane, input logic v, input logic [63:0] op, input logic [2:0] rm,
                              input logic dbl, input logic word, input logic uns, input logic [TAG_W-1:0] tag);
        if (lane) begin
            req1_valid = v; req1_operand = op; req1_rm = rm; req1_is_double = dbl;
            req1_is_word = word; req1_is_unsigned = uns; req1_tag = tag;
        end else begin
            req0_valid = v; req0_operand = op; req0_rm = rm; req0_is_double = dbl;
            req0_is_word = word; req0_is_unsigned = uns; req0_tag = tag;
        end
    endtask

    // Called just after a rising edge; returns just after the accepting edge
    task automatic apply_stimulus(input logic lane, input logic [63:0] op, input logic [2:0] rm,
                                  input logic dbl, input logic word, input logic uns, input logic [TAG_W-1:0] tag);
        int k;
        drive_lane(lane, 1'b1, op, rm, dbl, word, uns, tag);
        for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (lane ? req1_ready : req0_ready) break;
        end
        if (k == 20) check_output("accept_timeout", 64'd1, 64'd0);
        @(posedge clk); #1;
        drive_lane(lane, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic expect_result(input string name, input logic [63:0] data, input logic [4:0] flags,
                                 input logic ill, input logic lane, input logic [TAG_W-1:0] tag);
        @(negedge clk);
        check_output({name, "_lat1"}, {63'b0, res_valid}, 64'd0);
        @(negedge clk);
        check_output({name, "_valid"}, {63'b0, res_valid}, 64'd1);
        check_output({name, "_data"}, res_data, data);
        check_output({name, "_misc"}, {51'b0, res_fflags, res_illegal, res_lane, res_tag},
                     {51'b0, flags, ill, lane, tag});
        @(posedge clk); #1;
    endtask

    logic [63:0] pd;
    logic [4:0]  pf;
    logic        pi;
    int          acc_cnt, idx0, d0;
    logic        a0, a1;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; res_ready = 1'b1; frm_csr = 3'b000;
        drive_lane(1'b0, 1'b1, 64'd1, 3'b000, 1'b0, 1'b1, 1'b0, 6'd1);
        drive_lane(1'b1, 1'b1, 64'd2, 3'b000, 1'b0, 1'b1, 1'b0, 6'd2);

        model_cvt(64'h0000_0000_0100_0001, 3'b011, 3'b000, 1'b0, 1'b0, 1'b0, pd, pf, pi);
        check_output("model_rup", {pd[63:0]}, 64'hFFFF_FFFF_4B80_0001);
        model_cvt(64'h0020_0000_0000_0001, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, pd, pf, pi);
        check_output("model_dp_rne", pd, 64'h4340_0000_0000_0000);
        check_output("model_dp_nx", {59'b0, pf}, 64'd1);

        repeat (2) @(posedge clk);
        @(negedge clk);
        check_output("rst_ready0", {63'b0, req0_ready}, 64'd0);
        check_output("rst_ready1", {63'b0, req1_ready}, 64'd0);
        check_output("rst_busy", {63'b0, busy}, 64'd0);
        check_output("rst_valid", {63'b0, res_valid}, 64'd0);
        check_output("rst_data", res_data, 64'd0);
        check_output("rst_misc", {51'b0, res_fflags, res_illegal, res_lane, res_tag}, 64'd0);
        drive_lane(1'b0, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        drive_lane(1'b1, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] round-robin with both lanes requesting");
        d0 = delivered;
        drive_lane(1'b0, 1'b1, 64'd5, 3'b000, 1'b0, 1'b1, 1'b0, 6'd10);
        drive_lane(1'b1, 1'b1, 64'd7, 3'b000, 1'b0, 1'b1, 1'b0, 6'd11);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_output("rr_ready0", {63'b0, req0_ready}, {63'b0, (i % 2) == 0});
            check_output("rr_ready1", {63'b0, req1_ready}, {63'b0, (i % 2) == 1});
            if (i >= 2) check_output("rr_b2b", {63'b0, res_valid}, 64'd1);
        end
        @(posedge clk); #1;
        drive_lane(1'b0, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        drive_lane(1'b1, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("rr_tail", {63'b0, res_valid}, {63'b0, i < 2});
        end
        check_output("rr_delivered", 64'(delivered - d0), 64'd4);
        @(posedge clk); #1;

        $display("[TB] directed conversions");
        apply_stimulus(1'b0, 64'h1, 3'b000, 1'b0, 1'b1, 1'b0, 6'h15);
        expect_result("w_one_sp", 64'hFFFF_FFFF_3F80_0000, 5'd0, 1'b0, 1'b0, 6'h15);
        apply_stimulus(1'b1, 64'h0100_0001, 3'b000, 1'b0, 1'b0, 1'b0, 6'h21);
        expect_result("l_rne_sp", 64'hFFFF_FFFF_4B80_0000, 5'd1, 1'b0, 1'b1, 6'h21);
        apply_stimulus(1'b1, 64'h0100_0001, 3'b011, 1'b0, 1'b0, 1'b0, 6'h22);
        expect_result("l_rup_sp", 64'hFFFF_FFFF_4B80_0001, 5'd1, 1'b0, 1'b1, 6'h22);
        frm_csr = 3'b001;
        apply_stimulus(1'b1, 64'h0100_0001, 3'b111, 1'b0, 1'b0, 1'b0, 6'h23);
        frm_csr = 3'b011;
        expect_result("l_dyn_rtz", 64'hFFFF_FFFF_4B80_0000, 5'd1, 1'b0, 1'b1, 6'h23);
        frm_csr = 3'b000;
        apply_stimulus(1'b0, 64'h0020_0000_0000_0001, 3'b000, 1'b1, 1'b0, 1'b0, 6'h24);
        expect_result("l_rne_dp", 64'h4340_0000_0000_0000, 5'd1, 1'b0, 1'b0, 6'h24);
        apply_stimulus(1'b0, 64'hFFFF_FFFF, 3'b000, 1'b1, 1'b1, 1'b0, 6'h25);
        expect_result("w_m1_dp", 64'hBFF0_0000_0000_0000, 5'd0, 1'b0, 1'b0, 6'h25);
        apply_stimulus(1'b1, 64'hFFFF_FFFF_FEFF_FFFF, 3'b010, 1'b0, 1'b0, 1'b0, 6'h26);
        expect_result("l_rdn_neg", 64'hFFFF_FFFF_CB80_0001, 5'd1, 1'b0, 1'b1, 6'h26);
        apply_stimulus(1'b0, 64'hFFFF_FFFF, 3'b000, 1'b1, 1'b1, 1'b1, 6'h27);
        expect_result("wu_max_dp", 64'h41EF_FFFF_FFE0_0000, 5'd0, 1'b0, 1'b0, 6'h27);
        apply_stimulus(1'b1, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, 6'h28);
        expect_result("zero_sp", 64'hFFFF_FFFF_0000_0000, 5'd0, 1'b0, 1'b1, 6'h28);

        $display("[TB] backpressure then flush");
        res_ready = 1'b0;
        acc_cnt = 0;
        idx0 = 0;
        drive_lane(1'b0, 1'b1, 64'd3, 3'b000, 1'b1, 1'b0, 1'b0, 6'd20);
        drive_lane(1'b1, 1'b1, 64'd4, 3'b000, 1'b1, 1'b0, 1'b0, 6'd21);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            a0 = req0_valid & req0_ready;
            a1 = req1_valid & req1_ready;
            acc_cnt += int'(a0) + int'(a1);
            @(posedge clk); #1;
            if (a0) begin
                idx0++;
                if (idx0 < 2) drive_lane(1'b0, 1'b1, 64'd9, 3'b000, 1'b1, 1'b0, 1'b0, 6'd22);
                else          drive_lane(1'b0, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
            end
            if (a1) drive_lane(1'b1, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        end
        check_output("bp_accepts", 64'(acc_cnt), 64'd2);
        @(negedge clk);
        check_output("bp_hold_ready", {62'b0, req0_ready, req1_ready}, 64'd0);
        check_output("bp_pending", {63'b0, req0_valid | req1_valid}, 64'd1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check_output("flush_noaccept", {62'b0, req0_ready, req1_ready}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        res_ready = 1'b1;
        drive_lane(1'b0, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        drive_lane(1'b1, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        @(negedge clk);
        check_output("flush_valid", {63'b0, res_valid}, 64'd0);
        check_output("flush_busy", {63'b0, busy}, 64'd0);
        @(posedge clk); #1;

        $display("[TB] reserved rounding modes");
        apply_stimulus(1'b1, 64'h1, 3'b101, 1'b0, 1'b0, 1'b0, 6'h30);
        expect_result("ill_rm5", 64'h0, 5'd0, 1'b1, 1'b1, 6'h30);
        frm_csr = 3'b110;
        apply_stimulus(1'b0, 64'h0100_0001, 3'b111, 1'b0, 1'b0, 1'b0, 6'h31);
        expect_result("ill_dyn6", 64'h0, 5'd0, 1'b1, 1'b0, 6'h31);
        frm_csr = 3'b000;

        $display("[TB] reset mid-operation");
        apply_stimulus(1'b0, 64'h1234, 3'b000, 1'b1, 1'b0, 1'b0, 6'h32);
        rst_n = 1'b0;
        drive_lane(1'b0, 1'b1, 64'h77, 3'b000, 1'b1, 1'b0, 1'b0, 6'h33);
        @(negedge clk);
        check_output("midrst_valid", {63'b0, res_valid}, 64'd0);
        check_output("midrst_busy", {63'b0, busy}, 64'd0);
        check_output("midrst_ready", {63'b0, req0_ready}, 64'd0);
        drive_lane(1'b0, 1'b0, 64'h0, 3'b000, 1'b0, 1'b0, 1'b0, '0);
        @(posedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("midrst_drop", {63'b0, res_valid}, 64'd0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
